// File: rtl/csr.sv
// Control/status register block with ID, CTRL, STATUS, SCRATCH, IRQ_STATUS (W1C) and IRQ_MASK.
// Single-cycle CPU interface: every request is accepted and acknowledged on the following cycle.

package csr_pkg;
  localparam int CSR_MIN_ADDR_WIDTH = 5;
  localparam int CSR_DATA_WIDTH     = 32;

  typedef struct packed {
    logic [31:0] value;
  } csr__status__in_t;

  typedef struct packed {
    logic [7:0] hwset;
  } csr__irq_status__in_t;

  typedef struct packed {
    csr__status__in_t     status;
    csr__irq_status__in_t irq_status;
  } csr__in_t;

  typedef struct packed {
    logic [31:0] value;
  } csr__reg32__out_t;

  typedef struct packed {
    logic [7:0] value;
  } csr__reg8__out_t;

  typedef struct packed {
    csr__reg32__out_t ctrl;
    csr__reg32__out_t scratch;
    csr__reg8__out_t  irq_status;
    csr__reg8__out_t  irq_mask;
    logic             irq;
  } csr__out_t;
endpackage

module csr
  import csr_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        s_cpuif_req,
  input  logic        s_cpuif_req_is_wr,
  input  logic [4:0]  s_cpuif_addr,
  input  logic [31:0] s_cpuif_wr_data,
  input  logic [31:0] s_cpuif_wr_biten,
  output logic        s_cpuif_req_stall_wr,
  output logic        s_cpuif_req_stall_rd,
  output logic        s_cpuif_rd_ack,
  output logic        s_cpuif_rd_err,
  output logic [31:0] s_cpuif_rd_data,
  output logic        s_cpuif_wr_ack,
  output logic        s_cpuif_wr_err,
  input  csr__in_t    hwif_in,
  output csr__out_t   hwif_out
);

  localparam logic [31:0] ID_VALUE = 32'h5747_0001;

  localparam logic [2:0] IDX_ID         = 3'd0;
  localparam logic [2:0] IDX_CTRL       = 3'd1;
  localparam logic [2:0] IDX_STATUS     = 3'd2;
  localparam logic [2:0] IDX_SCRATCH    = 3'd3;
  localparam logic [2:0] IDX_IRQ_STATUS = 3'd4;
  localparam logic [2:0] IDX_IRQ_MASK   = 3'd5;

  logic [31:0] ctrl_reg, ctrl_next;
  logic [31:0] scratch_reg, scratch_next;
  logic [7:0]  irq_status_reg, irq_status_next;
  logic [7:0]  irq_mask_reg, irq_mask_next;
  logic [31:0] rd_data_reg, rd_data_next;
  logic        rd_ack_reg, wr_ack_reg;

  logic [2:0]  reg_idx;
  logic        wr_en, rd_en;
  logic [31:0] wr_bits_set;
  logic [7:0]  w1c_clr;

  assign reg_idx     = s_cpuif_addr[4:2];
  assign wr_en       = s_cpuif_req & s_cpuif_req_is_wr;
  assign rd_en       = s_cpuif_req & ~s_cpuif_req_is_wr;
  assign wr_bits_set = s_cpuif_wr_data & s_cpuif_wr_biten;
  assign w1c_clr     = (wr_en && reg_idx == IDX_IRQ_STATUS) ? wr_bits_set[7:0] : 8'h00;

  always_comb begin
    ctrl_next     = ctrl_reg;
    scratch_next  = scratch_reg;
    irq_mask_next = irq_mask_reg;
    if (wr_en) begin
      case (reg_idx)
        IDX_CTRL:     ctrl_next     = (ctrl_reg & ~s_cpuif_wr_biten) | wr_bits_set;
        IDX_SCRATCH:  scratch_next  = (scratch_reg & ~s_cpuif_wr_biten) | wr_bits_set;
        IDX_IRQ_MASK: irq_mask_next = (irq_mask_reg & ~s_cpuif_wr_biten[7:0]) | wr_bits_set[7:0];
        default:      ;
      endcase
    end
  end

  // Hardware set takes priority over a software clear of the same bit.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_irq_bit
      assign irq_status_next[gi] = hwif_in.irq_status.hwset[gi] |
                                   (irq_status_reg[gi] & ~w1c_clr[gi]);
    end
  endgenerate

  always_comb begin
    rd_data_next = 32'h0;
    if (rd_en) begin
      case (reg_idx)
        IDX_ID:         rd_data_next = ID_VALUE;
        IDX_CTRL:       rd_data_next = ctrl_reg;
        IDX_STATUS:     rd_data_next = hwif_in.status.value;
        IDX_SCRATCH:    rd_data_next = scratch_reg;
        IDX_IRQ_STATUS: rd_data_next = {24'h0, irq_status_reg};
        IDX_IRQ_MASK:   rd_data_next = {24'h0, irq_mask_reg};
        default:        rd_data_next = 32'h0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_reg       <= 32'h0;
      scratch_reg    <= 32'h0;
      irq_status_reg <= 8'h0;
      irq_mask_reg   <= 8'h0;
      rd_data_reg    <= 32'h0;
      rd_ack_reg     <= 1'b0;
      wr_ack_reg     <= 1'b0;
    end else begin
      ctrl_reg       <= ctrl_next;
      scratch_reg    <= scratch_next;
      irq_status_reg <= irq_status_next;
      irq_mask_reg   <= irq_mask_next;
      rd_data_reg    <= rd_data_next;
      rd_ack_reg     <= rd_en;
      wr_ack_reg     <= wr_en;
    end
  end

  assign s_cpuif_req_stall_wr = 1'b0;
  assign s_cpuif_req_stall_rd = 1'b0;
  assign s_cpuif_rd_err       = 1'b0;
  assign s_cpuif_wr_err       = 1'b0;
  assign s_cpuif_rd_ack       = rd_ack_reg;
  assign s_cpuif_rd_data      = rd_data_reg;
  assign s_cpuif_wr_ack       = wr_ack_reg;

  assign hwif_out.ctrl.value       = ctrl_reg;
  assign hwif_out.scratch.value    = scratch_reg;
  assign hwif_out.irq_status.value = irq_status_reg;
  assign hwif_out.irq_mask.value   = irq_mask_reg;
  assign hwif_out.irq              = |(irq_status_reg & irq_mask_reg);

endmodule

// File: tb/tb_csr.sv
// Scoreboard bench for csr: a register model predicts each ack and read value when a
// request is driven; a monitor pops the prediction in the cycle the response is due.

module tb_csr;
  import csr_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_cpuif_req;
  logic        s_cpuif_req_is_wr;
  logic [4:0]  s_cpuif_addr;
  logic [31:0] s_cpuif_wr_data;
  logic [31:0] s_cpuif_wr_biten;
  logic        s_cpuif_req_stall_wr, s_cpuif_req_stall_rd;
  logic        s_cpuif_rd_ack, s_cpuif_rd_err;
  logic [31:0] s_cpuif_rd_data;
  logic        s_cpuif_wr_ack, s_cpuif_wr_err;
  csr__in_t    hwif_in;
  csr__out_t   hwif_out;

  csr dut (
    .clk                  (clk),
    .rst                  (rst),
    .s_cpuif_req          (s_cpuif_req),
    .s_cpuif_req_is_wr    (s_cpuif_req_is_wr),
    .s_cpuif_addr         (s_cpuif_addr),
    .s_cpuif_wr_data      (s_cpuif_wr_data),
    .s_cpuif_wr_biten     (s_cpuif_wr_biten),
    .s_cpuif_req_stall_wr (s_cpuif_req_stall_wr),
    .s_cpuif_req_stall_rd (s_cpuif_req_stall_rd),
    .s_cpuif_rd_ack       (s_cpuif_rd_ack),
    .s_cpuif_rd_err       (s_cpuif_rd_err),
    .s_cpuif_rd_data      (s_cpuif_rd_data),
    .s_cpuif_wr_ack       (s_cpuif_wr_ack),
    .s_cpuif_wr_err       (s_cpuif_wr_err),
    .hwif_in              (hwif_in),
    .hwif_out             (hwif_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Register model
  logic [31:0] m_ctrl, m_scratch;
  logic [7:0]  m_irq_st, m_irq_mk;

  typedef struct {
    int          due;
    bit          is_wr;
    logic [31:0] data;
    string       tag;
  } exp_t;
  exp_t exp_q[$];

  function automatic logic [31:0] model_read(input logic [4:0] addr);
    case (addr[4:2])
      3'd0:    return 32'h5747_0001;
      3'd1:    return m_ctrl;
      3'd2:    return hwif_in.status.value;
      3'd3:    return m_scratch;
      3'd4:    return {24'h0, m_irq_st};
      3'd5:    return {24'h0, m_irq_mk};
      default: return 32'h0;
    endcase
  endfunction

  // One clock of stimulus; the model advances to the state after the coming edge.
  task automatic do_cycle(input bit req, input bit wr, input logic [4:0] addr,
                          input logic [31:0] d, input logic [31:0] be,
                          input logic [7:0] hwset, input bit rst_v, input string tag);
    exp_t e;
    logic [31:0] set_bits;
    logic [7:0]  clr;
    @(posedge clk);
    #1;
    rst                        = rst_v;
    s_cpuif_req                = req;
    s_cpuif_req_is_wr          = wr;
    s_cpuif_addr               = addr;
    s_cpuif_wr_data            = d;
    s_cpuif_wr_biten           = be;
    hwif_in.irq_status.hwset   = hwset;
    if (rst_v) begin
      m_ctrl = 0; m_scratch = 0; m_irq_st = 0; m_irq_mk = 0;
    end else begin
      set_bits = d & be;
      clr = (req && wr && addr[4:2] == 3'd4) ? set_bits[7:0] : 8'h0;
      if (req) begin
        e.due = cyc + 1; e.is_wr = wr; e.tag = tag;
        e.data = wr ? 32'h0 : model_read(addr);
        exp_q.push_back(e);
      end
      if (req && wr) begin
        case (addr[4:2])
          3'd1: m_ctrl    = (m_ctrl & ~be) | set_bits;
          3'd3: m_scratch = (m_scratch & ~be) | set_bits;
          3'd5: m_irq_mk  = (m_irq_mk & ~be[7:0]) | set_bits[7:0];
          default: ;
        endcase
      end
      m_irq_st = (m_irq_st & ~clr) | hwset;
    end
  endtask

  task automatic idle();
    do_cycle(1'b0, 1'b0, 5'h0, 32'h0, 32'h0, 8'h0, 1'b0, "idle");
  endtask

  task automatic wr_reg(input logic [4:0] a, input logic [31:0] d, input logic [31:0] be, input string tag);
    do_cycle(1'b1, 1'b1, a, d, be, 8'h0, 1'b0, tag);
  endtask

  task automatic rd_reg(input logic [4:0] a, input string tag);
    do_cycle(1'b1, 1'b0, a, 32'h0, 32'h0, 8'h0, 1'b0, tag);
  endtask

  task automatic check_hw(input string tag);
    idle();
    @(negedge clk);
    chk({tag, "_ctrl"},    hwif_out.ctrl.value, m_ctrl);
    chk({tag, "_scratch"}, hwif_out.scratch.value, m_scratch);
    chk({tag, "_irq_st"},  {24'h0, hwif_out.irq_status.value}, {24'h0, m_irq_st});
    chk({tag, "_irq_mk"},  {24'h0, hwif_out.irq_mask.value}, {24'h0, m_irq_mk});
    chk({tag, "_irq"},     {31'h0, hwif_out.irq}, {31'h0, |(m_irq_st & m_irq_mk)});
  endtask

  // Response monitor: one prediction is due per cycle at most.
  bit mon_en = 1'b0;
  always @(negedge clk) begin
    if (mon_en) begin
      chk("err_stall", {28'h0, s_cpuif_rd_err, s_cpuif_wr_err, s_cpuif_req_stall_wr, s_cpuif_req_stall_rd}, 32'h0);
      if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
        exp_t e;
        e = exp_q.pop_front();
        if (e.due < cyc) chk({e.tag, "_late"}, cyc, e.due);
        if (e.is_wr) begin
          chk({e.tag, "_wr_ack"}, {31'h0, s_cpuif_wr_ack}, 32'h1);
          chk({e.tag, "_rd_ack"}, {31'h0, s_cpuif_rd_ack}, 32'h0);
        end else begin
          chk({e.tag, "_rd_ack"}, {31'h0, s_cpuif_rd_ack}, 32'h1);
          chk({e.tag, "_rd_data"}, s_cpuif_rd_data, e.data);
          chk({e.tag, "_wr_ack"}, {31'h0, s_cpuif_wr_ack}, 32'h0);
        end
      end else begin
        chk("idle_acks", {30'h0, s_cpuif_rd_ack, s_cpuif_wr_ack}, 32'h0);
        chk("idle_rd_data", s_cpuif_rd_data, 32'h0);
      end
    end
  end

  initial begin
    rst = 1'b1;
    s_cpuif_req = 1'b0; s_cpuif_req_is_wr = 1'b0; s_cpuif_addr = '0;
    s_cpuif_wr_data = '0; s_cpuif_wr_biten = '0;
    hwif_in.status.value = 32'h0;
    hwif_in.irq_status.hwset = 8'h0;
    m_ctrl = 0; m_scratch = 0; m_irq_st = 0; m_irq_mk = 0;

    // Reset, including a write and hwset that must be dropped
    do_cycle(1'b0, 1'b0, 5'h0, 32'h0, 32'h0, 8'h0, 1'b1, "rst0");
    do_cycle(1'b1, 1'b1, 5'h0C, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 8'hFF, 1'b1, "rst_req");
    idle();
    @(negedge clk);
    mon_en = 1'b1;
    check_hw("reset");

    rd_reg(5'h00, "rd_id");
    rd_reg(5'h04, "rd_ctrl_rst");
    rd_reg(5'h0C, "rd_scratch_rst");

    // Partial-biten RW write
    wr_reg(5'h0C, 32'h1234_5678, 32'hFFFF_FFFF, "wr_scr_full");
    wr_reg(5'h0C, 32'hDEAD_BEEF, 32'h0000_FFFF, "wr_scr_half");
    rd_reg(5'h0C, "rd_scr");
    check_hw("scratch");
    chk("scratch_val", hwif_out.scratch.value, 32'h1234_BEEF);

    // Interrupt set / mask / W1C
    wr_reg(5'h14, 32'h0000_0004, 32'hFFFF_FFFF, "wr_mask");
    do_cycle(1'b0, 1'b0, 5'h0, 32'h0, 32'h0, 8'h05, 1'b0, "hwset");
    check_hw("irq_set");
    chk("irq_high", {31'h0, hwif_out.irq}, 32'h1);
    wr_reg(5'h10, 32'h0000_0004, 32'hFFFF_FFFF, "w1c_b2");
    check_hw("irq_clr");
    chk("irq_low", {31'h0, hwif_out.irq}, 32'h0);
    rd_reg(5'h10, "rd_irq_st");

    // Set beats simultaneous clear; then a plain clear works
    do_cycle(1'b1, 1'b1, 5'h10, 32'h1, 32'hFFFF_FFFF, 8'h01, 1'b0, "w1c_vs_set");
    rd_reg(5'h10, "rd_set_wins");
    wr_reg(5'h10, 32'h1, 32'h0, "w1c_no_biten");
    rd_reg(5'h10, "rd_no_biten");
    wr_reg(5'h10, 32'h1, 32'h1, "w1c_b0");
    rd_reg(5'h10, "rd_cleared");

    // RO and unmapped
    hwif_in.status.value = 32'hCAFE_0001;
    wr_reg(5'h08, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "wr_status");
    rd_reg(5'h08, "rd_status");
    wr_reg(5'h00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "wr_id");
    rd_reg(5'h00, "rd_id2");
    wr_reg(5'h1C, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "wr_unmapped");
    rd_reg(5'h1C, "rd_1c");
    rd_reg(5'h18, "rd_18");
    check_hw("ro");

    // Back-to-back with ignored low address bits
    wr_reg(5'h05, 32'hA5A5_0F0F, 32'hFFFF_FFFF, "b2b_wr_ctrl");
    wr_reg(5'h0E, 32'h0BAD_F00D, 32'hFF00_FF00, "b2b_wr_scr");
    wr_reg(5'h17, 32'hFFFF_FF3C, 32'hFFFF_FFFF, "b2b_wr_mask");
    rd_reg(5'h04, "b2b_rd_ctrl");
    rd_reg(5'h0C, "b2b_rd_scr");
    rd_reg(5'h14, "b2b_rd_mask");

    // Random mix
    for (int i = 0; i < 60; i++) begin
      logic [4:0] a;
      a = 5'($urandom_range(0, 31));
      do_cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), a,
               $urandom, ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFF : $urandom,
               ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h0, 1'b0, "rand");
    end
    check_hw("rand");

    // Reset mid-stream with a coinciding request
    wr_reg(5'h04, 32'h1111_2222, 32'hFFFF_FFFF, "pre_rst_ctrl");
    wr_reg(5'h0C, 32'h3333_4444, 32'hFFFF_FFFF, "pre_rst_scr");
    do_cycle(1'b1, 1'b1, 5'h14, 32'hFF, 32'hFFFF_FFFF, 8'hFF, 1'b1, "mid_rst");
    rd_reg(5'h04, "post_rst_ctrl");
    rd_reg(5'h0C, "post_rst_scr");
    rd_reg(5'h14, "post_rst_mask");
    rd_reg(5'h10, "post_rst_irq");
    check_hw("post_rst");

    repeat (3) idle();
    repeat (2) @(negedge clk);
    chk("queue_drained", exp_q.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=%0d exp=%0d", cyc, 0);
    $fatal(1, "timeout");
  end

endmodule
